// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
//
// Front end for the 7-bit adder. Four raw push-buttons and a 4-bit switch
// bank are synchronised and the buttons are debounced. Each accepted press
// (the debounced level rising) loads one nibble of operand a or b from the
// synchronised switches. The module flags when all four nibbles have been
// loaded since the last clear.
//
// Parameters
//   DEBOUNCE_CYCLES  number of consecutive stable cycles before a new button
//                    level is accepted (>= 2)
//   CNT_W            debounce counter width; must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk             in   1  system clock
//   rst_n           in   1  asynchronous active-low reset
//   x               in   4  raw switch nibble (asynchronous)
//   pb1             in   1  raw button: load a[3:0]
//   pb2             in   1  raw button: load a[6:4]
//   pb3             in   1  raw button: load b[3:0]
//   pb4             in   1  raw button: load b[6:4]
//   clr             in   1  synchronous clear of operands, strobe and mask
//   a               out  7  operand A to adder
//   b               out  7  operand B to adder
//   load_strobe     out  4  one-cycle pulse per accepted press, bit i = pb(i+1)
//   loaded_mask     out  4  bit i set once pb(i+1) nibble loaded since clear
//   operands_valid  out  1  all four nibbles loaded (&loaded_mask)
// ---------------------------------------------------------------------------
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] x,
    input  logic       pb1,
    input  logic       pb2,
    input  logic       pb3,
    input  logic       pb4,
    input  logic       clr,
    output logic [6:0] a,
    output logic [6:0] b,
    output logic [3:0] load_strobe,
    output logic [3:0] loaded_mask,
    output logic       operands_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       pb_raw;
    logic [3:0]       pb_meta;
    logic [3:0]       pb_s;
    logic [3:0]       x_meta;
    logic [3:0]       x_s;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       rise;

    // Bit i of every 4-bit button vector corresponds to pb(i+1).
    assign pb_raw = {pb4, pb3, pb2, pb1};

    // Two-flop synchronisers. The switches are synchronised the same way as
    // the buttons; they are only sampled long after they have settled.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the
    // meta -> s chain a real two-stage shift rather than a single wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_meta <= '0;
            pb_s    <= '0;
            x_meta  <= '0;
            x_s     <= '0;
        end else begin
            pb_meta <= pb_raw;
            pb_s    <= pb_meta;
            x_meta  <= x;
            x_s     <= x_meta;
        end
    end

    // Per-button debounce. The counter measures how long pb_s has disagreed
    // with the accepted level; any agreement restarts it, so the level only
    // flips after DEBOUNCE_CYCLES uninterrupted differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pb_s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= pb_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is accepted on the very edge where db goes 0 -> 1, so the
    // nibble load is decoded from the pre-edge debounce state instead of
    // waiting a cycle for db to be visible high.
    // NOTE: every bit is assigned on every pass through this block; a path
    // that left rise unassigned would infer a latch.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 4; i++) begin
            rise[i] = pb_s[i] & ~db[i] & (cnt[i] == CNT_MAX);
        end
    end

    // Operand registers, strobe and mask. clr has priority over any load in
    // the same cycle but leaves the debounce state alone, so a button that
    // is still held across a clear does not load again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            load_strobe <= '0;
            loaded_mask <= '0;
        end else if (clr) begin
            a           <= '0;
            b           <= '0;
            load_strobe <= '0;
            loaded_mask <= '0;
        end else begin
            load_strobe <= rise;
            loaded_mask <= loaded_mask | rise;
            if (rise[0]) a[3:0] <= x_s;
            if (rise[1]) a[6:4] <= x_s[2:0];
            if (rise[2]) b[3:0] <= x_s;
            if (rise[3]) b[6:4] <= x_s[2:0];
        end
    end

    assign operands_valid = &loaded_mask;

endmodule

// File: tb/tb_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_loader
//
// Self-checking bench for operand_loader with DEBOUNCE_CYCLES = 4.
// Every accepted press pushes its expected strobe/operand/mask snapshot onto
// a scoreboard queue; a monitor pops and compares whenever the DUT raises
// load_strobe, and flags any strobe nobody asked for. Scenario tasks add
// their own inline checks of latency, clear and reset behaviour.
// ---------------------------------------------------------------------------
module tb_operand_loader;

    localparam int DB = 4;

    typedef struct packed {
        logic [3:0] strobe;
        logic [6:0] a;
        logic [6:0] b;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] x;
    logic       pb1, pb2, pb3, pb4;
    logic       clr;
    logic [6:0] a, b;
    logic [3:0] load_strobe, loaded_mask;
    logic       operands_valid;

    int vectors    = 0;
    int miscompares = 0;

    exp_t       sb_q [$];
    logic [6:0] exp_a;
    logic [6:0] exp_b;
    logic [3:0] exp_mask;

    operand_loader #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .x              (x),
        .pb1            (pb1),
        .pb2            (pb2),
        .pb3            (pb3),
        .pb4            (pb4),
        .clr            (clr),
        .a              (a),
        .b              (b),
        .load_strobe    (load_strobe),
        .loaded_mask    (loaded_mask),
        .operands_valid (operands_valid)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: any visible strobe must match the next expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && load_strobe !== 4'b0000) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got strobe=%b a=%h b=%h mask=%b, required no strobe",
                         load_strobe, a, b, loaded_mask);
            end else begin
                e = sb_q.pop_front();
                if ({load_strobe, a, b, loaded_mask} !== e) begin
                    miscompares++;
                    $display("FAIL strobe_snapshot: got strobe=%b a=%h b=%h mask=%b, required strobe=%b a=%h b=%h mask=%b",
                             load_strobe, a, b, loaded_mask, e.strobe, e.a, e.b, e.mask);
                end
            end
        end
    end

    task automatic set_pb(input int idx, input logic v);
        case (idx)
            0: pb1 = v;
            1: pb2 = v;
            2: pb3 = v;
            default: pb4 = v;
        endcase
    endtask

    // Reference model of one accepted press.
    task automatic model_load(input int idx, input logic [3:0] xv);
        case (idx)
            0: exp_a[3:0] = xv;
            1: exp_a[6:4] = xv[2:0];
            2: exp_b[3:0] = xv;
            default: exp_b[6:4] = xv[2:0];
        endcase
        exp_mask[idx] = 1'b1;
    endtask

    // Full press/hold/release of a single button with an expected load.
    task automatic press_and_release(input int idx, input logic [3:0] xv);
        @(negedge clk);
        x = xv;
        set_pb(idx, 1'b1);
        model_load(idx, xv);
        sb_q.push_back({4'(1 << idx), exp_a, exp_b, exp_mask});
        repeat (9) @(negedge clk);
        set_pb(idx, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a, b, load_strobe, loaded_mask, operands_valid} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got a=%h b=%h strobe=%b mask=%b valid=%b, required all zero",
                     a, b, load_strobe, loaded_mask, operands_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = '0; exp_b = '0; exp_mask = '0;
    endtask

    task automatic test_single_load;
        @(negedge clk);
        x   = 4'hA;
        pb1 = 1'b1;
        model_load(0, 4'hA);
        sb_q.push_back({4'b0001, exp_a, exp_b, exp_mask});
        repeat (5) @(negedge clk);
        vectors++;
        if (a !== 7'h00) begin
            miscompares++;
            $display("FAIL load_not_early: got a=%h, required 00 before edge E5", a);
        end
        @(negedge clk);
        vectors++;
        if (a !== 7'h0A || load_strobe !== 4'b0001 || operands_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_at_e5: got a=%h strobe=%b valid=%b, required a=0a strobe=0001 valid=0",
                     a, load_strobe, operands_valid);
        end
        @(negedge clk);
        vectors++;
        if (load_strobe !== 4'b0000) begin
            miscompares++;
            $display("FAIL strobe_one_cycle: got strobe=%b, required 0000", load_strobe);
        end
        repeat (6) @(negedge clk);
        pb1 = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (a !== 7'h0A || loaded_mask !== 4'b0001) begin
            miscompares++;
            $display("FAIL release_no_load: got a=%h mask=%b, required a=0a mask=0001", a, loaded_mask);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        x = 4'hC;
        pb3 = 1'b1; repeat (3) @(negedge clk);
        pb3 = 1'b0; @(negedge clk);
        pb3 = 1'b1; repeat (3) @(negedge clk);
        pb3 = 1'b0; repeat (8) @(negedge clk);
        vectors++;
        if (b !== 7'h00 || loaded_mask !== 4'b0001) begin
            miscompares++;
            $display("FAIL glitch_rejected: got b=%h mask=%b, required b=00 mask=0001", b, loaded_mask);
        end
        press_and_release(2, 4'hC);
        vectors++;
        if (b !== 7'h0C || loaded_mask !== 4'b0101) begin
            miscompares++;
            $display("FAIL glitch_then_hold: got b=%h mask=%b, required b=0c mask=0101", b, loaded_mask);
        end
    endtask

    task automatic test_full_load;
        press_and_release(0, 4'h5);
        press_and_release(1, 4'hF);
        press_and_release(2, 4'h3);
        press_and_release(3, 4'h1);
        vectors++;
        if (a !== 7'h75 || b !== 7'h13 || loaded_mask !== 4'hF || operands_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_load: got a=%h b=%h mask=%h valid=%b, required a=75 b=13 mask=f valid=1",
                     a, b, loaded_mask, operands_valid);
        end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        x   = 4'h6;
        pb2 = 1'b1;
        pb4 = 1'b1;
        model_load(1, 4'h6);
        model_load(3, 4'h6);
        sb_q.push_back({4'b1010, exp_a, exp_b, exp_mask});
        repeat (6) @(negedge clk);
        vectors++;
        if (a !== 7'h65 || b !== 7'h63 || load_strobe !== 4'b1010) begin
            miscompares++;
            $display("FAIL simultaneous: got a=%h b=%h strobe=%b, required a=65 b=63 strobe=1010",
                     a, b, load_strobe);
        end
        repeat (3) @(negedge clk);
        pb2 = 1'b0;
        pb4 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_clr_priority;
        @(negedge clk);
        x   = 4'h9;
        pb1 = 1'b1;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_a = '0; exp_b = '0; exp_mask = '0;
        vectors++;
        if ({a, b, loaded_mask, load_strobe, operands_valid} !== 23'd0) begin
            miscompares++;
            $display("FAIL clr_wins: got a=%h b=%h mask=%b strobe=%b valid=%b, required all zero",
                     a, b, loaded_mask, load_strobe, operands_valid);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (a !== 7'h00 || loaded_mask !== 4'b0000) begin
            miscompares++;
            $display("FAIL held_no_reload: got a=%h mask=%b, required a=00 mask=0000", a, loaded_mask);
        end
        pb1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_count;
        press_and_release(0, 4'h7);
        @(negedge clk);
        x   = 4'h2;
        pb4 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a, b, load_strobe, loaded_mask, operands_valid} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_immediate: got a=%h b=%h strobe=%b mask=%b valid=%b, required all zero",
                     a, b, load_strobe, loaded_mask, operands_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = '0; exp_b = '0; exp_mask = '0;
        model_load(3, 4'h2);
        sb_q.push_back({4'b1000, exp_a, exp_b, exp_mask});
        repeat (5) @(negedge clk);
        vectors++;
        if (b !== 7'h00) begin
            miscompares++;
            $display("FAIL count_restarted: got b=%h, required 00 before edge E5", b);
        end
        @(negedge clk);
        vectors++;
        if (b !== 7'h20 || loaded_mask !== 4'b1000) begin
            miscompares++;
            $display("FAIL reload_after_reset: got b=%h mask=%b, required b=20 mask=1000", b, loaded_mask);
        end
        repeat (3) @(negedge clk);
        pb4 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        x     = 4'h0;
        pb1   = 1'b0; pb2 = 1'b0; pb3 = 1'b0; pb4 = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_single_load;
        test_glitch;
        test_full_load;
        test_simultaneous;
        test_clr_priority;
        test_reset_mid_count;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_strobes: got %0d expected loads never seen, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
